reg_bank: RTL and testbench

//  Parametrised general-purpose register bank for the datapath.

---
 rtl/reg_bank_if.sv | 30 +++
 rtl/reg_bank.sv | 127 ++++++++++++
 tb/tb_reg_bank.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Op/write and dual read port bundle between the Control Unit / ALU and the register bank.
// Handshake: wr_en+op act as a valid with no back-pressure; the bank answers every valid
// non-NOP request one cycle later with exactly one of wr_ack (done) or wr_err (bad address).
interface reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [2:0]        op;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [WIDTH-1:0]  rd_a_data;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [WIDTH-1:0]  rd_b_data;
  logic              flag_z;
  logic              flag_c;
  logic              wr_ack;
  logic              wr_err;

  modport master (
    output wr_en, op, wr_addr, wr_data, rd_a_addr, rd_b_addr,
    input  rd_a_data, rd_b_data, flag_z, flag_c, wr_ack, wr_err
  );

  modport slave (
    input  wr_en, op, wr_addr, wr_data, rd_a_addr, rd_b_addr,
    output rd_a_data, rd_b_data, flag_z, flag_c, wr_ack, wr_err
  );
endinterface

// File: rtl/reg_bank.sv
// General-purpose register bank: in-place ops on one register per cycle with Z/C flags,
// two combinational read ports with optional same-cycle forwarding of the write result.
module reg_bank #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 0
) (
  input  logic     clk,
  input  logic     reset,
  reg_bank_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_INC  = 3'b011,
    OP_DEC  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ADD  = 3'b111
  } op_e;

  localparam logic [ADDR_W:0]  LP_NREGS = (ADDR_W+1)'(NREGS);
  localparam logic [WIDTH-1:0] LP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_wr_ack;
  logic             r_wr_err;

  op_e              w_op;
  logic             w_wr_addr_ok;
  logic             w_req;
  logic             w_accept;
  logic             w_reject;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic [WIDTH:0]   w_sum;
  logic             w_rd_a_ok;
  logic             w_rd_b_ok;
  logic [WIDTH-1:0] w_rd_a_data;
  logic [WIDTH-1:0] w_rd_b_data;

  assign w_op         = op_e'(bus.op);
  assign w_wr_addr_ok = ({1'b0, bus.wr_addr} < LP_NREGS);
  assign w_req        = bus.wr_en && (w_op != OP_NOP);
  assign w_accept     = w_req && w_wr_addr_ok;
  assign w_reject     = w_req && !w_wr_addr_ok;
  assign w_cur        = w_wr_addr_ok ? r_regs[bus.wr_addr] : '0;

  // Result and carry of the selected op; flag_c passes through for ops that leave it alone.
  always_comb begin
    w_res   = w_cur;
    w_res_c = r_flag_c;
    w_sum   = '0;
    case (w_op)
      OP_LOAD: w_res = bus.wr_data;
      OP_CLR:  w_res = '0;
      OP_INC: begin
        w_sum   = {1'b0, w_cur} + {1'b0, LP_ONE};
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
      end
      OP_DEC: begin
        w_res   = w_cur - LP_ONE;
        w_res_c = (w_cur == '0);
      end
      OP_SHL: begin
        w_res   = {w_cur[WIDTH-2:0], r_flag_c};
        w_res_c = w_cur[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {r_flag_c, w_cur[WIDTH-1:1]};
        w_res_c = w_cur[0];
      end
      OP_ADD: begin
        w_sum   = {1'b0, w_cur} + {1'b0, bus.wr_data};
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_ack <= w_accept;
      r_wr_err <= w_reject;
      if (w_accept) begin
        r_regs[bus.wr_addr] <= w_res;
        r_flag_z            <= (w_res == '0);
        r_flag_c            <= w_res_c;
      end
    end
  end

  assign w_rd_a_ok = ({1'b0, bus.rd_a_addr} < LP_NREGS);
  assign w_rd_b_ok = ({1'b0, bus.rd_b_addr} < LP_NREGS);

  // Out-of-range addresses read as zero; forwarding only ever matches a valid write address.
  always_comb begin
    w_rd_a_data = w_rd_a_ok ? r_regs[bus.rd_a_addr] : '0;
    w_rd_b_data = w_rd_b_ok ? r_regs[bus.rd_b_addr] : '0;
    if (BYPASS != 0) begin
      if (w_accept && (bus.wr_addr == bus.rd_a_addr)) w_rd_a_data = w_res;
      if (w_accept && (bus.wr_addr == bus.rd_b_addr)) w_rd_b_data = w_res;
    end
  end

  assign bus.rd_a_data = w_rd_a_data;
  assign bus.rd_b_data = w_rd_b_data;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.wr_err    = r_wr_err;

endmodule

// File: tb/tb_reg_bank.sv
// Drives two bank instances (4 regs no forwarding, 3 regs with forwarding) with the same
// op stream and compares both against an arithmetic model of registers and flags.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_en;
  logic [2:0] t_op;
  logic [1:0] t_addr;
  logic [7:0] t_data;
  logic [1:0] t_ra;
  logic [1:0] t_rb;

  int n_vec = 0;
  int n_err = 0;

  // model state per instance
  int m_reg [2][4];
  int m_z [2];
  int m_c [2];
  int m_ack [2];
  int m_err [2];
  int nregs [2] = '{4, 3};
  int bypass [2] = '{0, 1};

  logic [7:0] o_rd_a [2];
  logic [7:0] o_rd_b [2];
  logic       o_z [2];
  logic       o_c [2];
  logic       o_ack [2];
  logic       o_err [2];

  reg_bank_if #(.WIDTH(8), .ADDR_W(2)) if0 ();
  reg_bank_if #(.WIDTH(8), .ADDR_W(2)) if1 ();

  reg_bank #(.WIDTH(8), .NREGS(4), .ADDR_W(2), .BYPASS(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  reg_bank #(.WIDTH(8), .NREGS(3), .ADDR_W(2), .BYPASS(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  assign if0.wr_en = t_en;    assign if1.wr_en = t_en;
  assign if0.op = t_op;       assign if1.op = t_op;
  assign if0.wr_addr = t_addr; assign if1.wr_addr = t_addr;
  assign if0.wr_data = t_data; assign if1.wr_data = t_data;
  assign if0.rd_a_addr = t_ra; assign if1.rd_a_addr = t_ra;
  assign if0.rd_b_addr = t_rb; assign if1.rd_b_addr = t_rb;

  assign o_rd_a[0] = if0.rd_a_data; assign o_rd_a[1] = if1.rd_a_data;
  assign o_rd_b[0] = if0.rd_b_data; assign o_rd_b[1] = if1.rd_b_data;
  assign o_z[0] = if0.flag_z;       assign o_z[1] = if1.flag_z;
  assign o_c[0] = if0.flag_c;       assign o_c[1] = if1.flag_c;
  assign o_ack[0] = if0.wr_ack;     assign o_ack[1] = if1.wr_ack;
  assign o_err[0] = if0.wr_err;     assign o_err[1] = if1.wr_err;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_read(input int k, input int a);
    return (a < nregs[k]) ? m_reg[k][a] : 0;
  endfunction

  // What the op would do to instance k: acceptance, rejection, new value, new carry.
  task automatic m_eval(input int k, output int acc, output int rej, output int nr, output int nc);
    int r, s;
    acc = 0; rej = 0; nr = 0; nc = m_c[k];
    if (!t_en || t_op == 3'd0) return;
    if (int'(t_addr) >= nregs[k]) begin rej = 1; return; end
    acc = 1;
    r = m_reg[k][t_addr];
    case (t_op)
      3'd1: nr = t_data;
      3'd2: nr = 0;
      3'd3: begin s = r + 1; nc = (s > 255); nr = s % 256; end
      3'd4: begin nc = (r == 0); nr = (r + 255) % 256; end
      3'd5: begin nc = (r >= 128); nr = (r * 2) % 256 + m_c[k]; end
      3'd6: begin nc = r % 2; nr = r / 2 + m_c[k] * 128; end
      default: begin s = r + t_data; nc = (s > 255); nr = s % 256; end
    endcase
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.z%0d", tag, k), o_z[k], m_z[k]);
      chk($sformatf("%s.c%0d", tag, k), o_c[k], m_c[k]);
      chk($sformatf("%s.ack%0d", tag, k), o_ack[k], m_ack[k]);
      chk($sformatf("%s.err%0d", tag, k), o_err[k], m_err[k]);
    end
  endtask

  // One cycle: drive at negedge, check reads before the edge, update model, check after it.
  task automatic cyc(input logic en, input logic [2:0] op, input logic [1:0] addr,
                     input logic [7:0] data, input logic [1:0] ra, input logic [1:0] rb,
                     input string tag);
    int acc [2], rej [2], nr [2], nc [2];
    int ea, eb;
    @(negedge clk);
    t_en = en; t_op = op; t_addr = addr; t_data = data; t_ra = ra; t_rb = rb;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_eval(k, acc[k], rej[k], nr[k], nc[k]);
      ea = m_read(k, ra);
      eb = m_read(k, rb);
      if (bypass[k] != 0 && acc[k] != 0 && addr == ra) ea = nr[k];
      if (bypass[k] != 0 && acc[k] != 0 && addr == rb) eb = nr[k];
      chk($sformatf("%s.rda%0d", tag, k), o_rd_a[k], ea);
      chk($sformatf("%s.rdb%0d", tag, k), o_rd_b[k], eb);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = acc[k];
      m_err[k] = rej[k];
      if (acc[k] != 0) begin
        m_reg[k][addr] = nr[k];
        m_z[k] = (nr[k] == 0);
        m_c[k] = nc[k];
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    t_en = 1'b1; t_op = 3'd1; t_addr = 2'd1; t_data = 8'h55;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
      m_z[k] = 0; m_c[k] = 0; m_ack[k] = 0; m_err[k] = 0;
    end
    #1;
    check_outs(tag);
    @(negedge clk);
    reset = 1'b0;
    t_en = 1'b0; t_op = 3'd0;
  endtask

  initial begin
    reset = 1'b1;
    t_en = 1'b0; t_op = '0; t_addr = '0; t_data = '0; t_ra = '0; t_rb = '0;
    do_reset("rst");
    cyc(0, 3'd0, 2'd0, 8'h00, 2'd0, 2'd1, "idle0");
    cyc(0, 3'd0, 2'd0, 8'h00, 2'd2, 2'd3, "idle1");
    // load then increment to wrap with carry
    cyc(1, 3'd1, 2'd1, 8'hFF, 2'd1, 2'd0, "ld_r1");
    cyc(1, 3'd3, 2'd1, 8'h00, 2'd1, 2'd1, "inc_r1");
    cyc(0, 3'd3, 2'd1, 8'h00, 2'd1, 2'd0, "hold");
    // clear, borrow, add back to zero
    cyc(1, 3'd2, 2'd2, 8'h00, 2'd2, 2'd1, "clr_r2");
    cyc(1, 3'd4, 2'd2, 8'h00, 2'd2, 2'd2, "dec_r2");
    cyc(1, 3'd7, 2'd2, 8'h01, 2'd2, 2'd0, "add_r2");
    // rotate through carry
    cyc(1, 3'd1, 2'd0, 8'h81, 2'd0, 2'd2, "ld_r0");
    cyc(1, 3'd5, 2'd0, 8'h00, 2'd0, 2'd1, "shl_r0");
    cyc(1, 3'd6, 2'd0, 8'h00, 2'd0, 2'd3, "shr_r0");
    // address 3: valid on the 4-reg instance, rejected on the 3-reg one
    cyc(1, 3'd1, 2'd3, 8'h5A, 2'd3, 2'd3, "ld_r3");
    cyc(1, 3'd2, 2'd3, 8'h00, 2'd3, 2'd0, "clr_r3");
    cyc(1, 3'd1, 2'd2, 8'h5A, 2'd2, 2'd2, "byp_r2");
    cyc(1, 3'd0, 2'd2, 8'h11, 2'd2, 2'd1, "nop");
    for (int n = 0; n < 500; n++) begin
      if (n == 250) do_reset("rst_mid");
      cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $sformatf("rnd%0d", n));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
